cache_controller: RTL and testbench
===================================

# cache_controller

Two-way set-associative, write-through, read-allocate cache controller for the MEM stage. It sits between the MEM-stage memory request (read/write, 32-bit word) and the SRAM controller, which returns 64-bit lines. The block owns the tag/valid/data/LRU arrays and the FSM that sequences lookup, line fill and write-through. It drives `ready`, which the pipeline uses as its stall (stall = ~ready).

## Interface
Parameters:
- `SETS`, 64: number of sets; index width = log2(SETS) = 6.
- `TAG_W`, 10: tag width; tag = addr[18:9].

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  read request; held until `ready`.
- `wr_en`  in  1  write request; held until `ready`.
- `address`  in  32  byte address; addr[2] = word select, addr[8:3] = index, addr[18:9] = tag; bits [31:19] ignored.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; valid when `ready` and `rd_en`.
- `ready`  out  1  request complete this cycle, or no request pending.
- `sram_rd_en`  out  1  line read request to the SRAM controller.
- `sram_wr_en`  out  1  word write request to the SRAM controller.
- `sram_address`  out  32  {address[31:3],3'b000} for reads; `address` for writes.
- `sram_wdata`  out  32  equals `wdata`.
- `sram_rdata`  in  64  fetched line; [31:0] = word 0, [63:32] = word 1.
- `sram_ready`  in  1  SRAM transaction done this cycle.

## Operation
- Per set:
  - way0 and way1 each have valid (1b), tag (TAG_W) and data (64b).
  - `lru` (1b) is the way to evict next.
- Hit in way w: valid_w && tag_w == addr[18:9]. Both ways are never valid with the same tag; the fill rule guarantees this.
- FSM states: IDLE, FILL, WRITE.
- IDLE, read hit:
  - `ready`=1 combinationally.
  - `rdata` = the hit way's data word selected by addr[2].
  - At the clock edge, lru := ~w. Stay in IDLE.
- IDLE, read miss: `ready`=0; next state FILL.
- IDLE, write (hit or miss): `ready`=0; next state WRITE.
- `rd_en` and `wr_en` both high: treated as a write.
- FILL:
  - `sram_rd_en`=1 until `sram_ready`.
  - On `sram_ready`:
    - Victim = way0 if !valid0; else way1 if !valid1; else `lru`.
    - Victim gets data := `sram_rdata`, tag := addr[18:9], valid := 1; lru := ~victim.
    - `ready`=1 and `rdata` = `sram_rdata` word selected by addr[2], both in the same cycle.
    - Next state IDLE.
- WRITE:
  - `sram_wr_en`=1 until `sram_ready`.
  - On `sram_ready`:
    - On hit, the hit way's word addr[2] := `wdata` and lru := ~w.
    - On miss, no allocation.
    - `ready`=1; next state IDLE.
- `ready` = 1 in IDLE when neither `rd_en` nor `wr_en` is asserted.

## Timing
- Reset:
  - State := IDLE; all valid bits := 0; all lru := 0.
  - Outputs after reset: `ready`=1, `rdata`=0, `sram_rd_en`=0, `sram_wr_en`=0, `sram_address`=0, `sram_wdata`=0.
  - Data and tag arrays need not be reset.
- Read hit latency: 0 wait cycles; `ready` in the request cycle.
- Miss latency:
  - `sram_rd_en` rises the cycle after the request.
  - `ready` asserts in the cycle `sram_ready` is sampled high: total = 1 + SRAM latency.
- Write latency: same as miss, using `sram_wr_en`.
- `sram_rd_en`/`sram_wr_en` are decoded from the registered state only (no combinational path from `rd_en`/`wr_en`). They deassert the cycle after `sram_ready`.
- Requester keeps `address`, `wdata`, `rd_en`, `wr_en` stable from request until `ready`. A back-to-back request may be presented the cycle after `ready`.
- `sram_ready` seen outside FILL/WRITE is ignored.
- `rst` mid-FILL/WRITE: the transaction is abandoned and no array update occurs. SRAM enables are 0 the cycle after `rst`.
- Read hit to a set in the same cycle a fill to that set completes cannot occur (single outstanding request).

## Structure
- Shared package `cache_pkg`:
  - Parameters `SETS`, `TAG_W`, `INDEX_W`.
  - State enum {IDLE, FILL, WRITE}.
  - Address field slice constants (offset [2:0], index [8:3], tag [18:9]).
- One combinational sub-module, `cache_lookup`:
  - Inputs: both ways' tag/valid/data, address tag, word select.
  - Outputs: hit, hit_way, selected word.
- FSM, arrays and victim/LRU logic stay in `cache_controller`.

## Test plan
- Cold read 0x0000_0010:
  - `sram_rd_en` the next cycle.
  - SRAM returns 0x2222_2222_1111_1111 → `ready` with `rdata`=0x1111_1111.
  - Way0 set 2 valid; lru[2]=1.
- Repeat read of 0x0000_0014: `ready` in the same cycle, `rdata`=0x2222_2222, no SRAM activity.
- Three tags to set 2 (0x010, 0x210, 0x410), then read 0x010 again:
  - Third fill evicts way0 (LRU).
  - The final read misses and evicts way1 (tag 0x210).
- Write 0xDEAD_BEEF to cached 0x0000_0014: `sram_wr_en` until `sram_ready`, then read 0x014 hits with 0xDEAD_BEEF.
- Write to an uncached address: write-through occurs and the next read of that address misses (no allocate).
- Assert `rst` during FILL before `sram_ready`:
  - Enables drop; `ready`=1.
  - All sets invalid: read 0x010 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the MEM-stage cache controller: geometry
// parameters, FSM state encoding, address field positions and small helpers.
// Ports: none (package).
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int SETS    = 64;
    localparam int TAG_W   = 10;
    localparam int INDEX_W = $clog2(SETS);

    // Byte address layout: [2:0] offset (bit 2 selects the word inside a
    // 64-bit line), [8:3] set index, [18:9] tag, [31:19] ignored by the cache.
    localparam int OFF_LSB  = 0;
    localparam int OFF_MSB  = 2;
    localparam int WSEL_BIT = 2;
    localparam int IDX_LSB  = 3;
    localparam int IDX_MSB  = 8;
    localparam int TAG_LSB  = 9;
    localparam int TAG_MSB  = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    // Line-aligned address sent to the SRAM controller for a fill.
    function automatic logic [31:0] line_addr(input logic [31:0] addr);
        return {addr[31:IDX_LSB], 3'b000};
    endfunction

endpackage : cache_pkg

// File: rtl/cache_if.sv
// -----------------------------------------------------------------------------
// cache_if
// MEM-stage request bus between the pipeline (master) and the cache (slave).
// Signals:
//   rd_en, wr_en  request strobes, held until ready
//   address       byte address
//   wdata         write data
//   rdata         read data, valid when ready && rd_en
//   ready         request complete this cycle, or nothing pending
// -----------------------------------------------------------------------------
interface cache_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, wdata,
        input  rdata, ready
    );

    modport slave (
        input  rd_en, wr_en, address, wdata,
        output rdata, ready
    );

endinterface : cache_if

// File: rtl/cache_lookup.sv
// -----------------------------------------------------------------------------
// cache_lookup
// Purely combinational tag compare for one set of the two-way cache.
// Inputs : valid/tag/data of way0 and way1, the request tag, word select.
// Outputs: hit, hit_way (0/1), and the 32-bit word of the hitting way
//          selected by word_sel (way0's word when there is no hit).
// -----------------------------------------------------------------------------
module cache_lookup
    import cache_pkg::*;
#(
    parameter int TAG_W = cache_pkg::TAG_W
) (
    input  logic             valid0,
    input  logic             valid1,
    input  logic [TAG_W-1:0] tag0,
    input  logic [TAG_W-1:0] tag1,
    input  logic [63:0]      data0,
    input  logic [63:0]      data1,
    input  logic [TAG_W-1:0] addr_tag,
    input  logic             word_sel,
    output logic             hit,
    output logic             hit_way,
    output logic [31:0]      word
);

    logic        hit0;
    logic        hit1;
    logic [63:0] line;

    always_comb begin
        hit0    = valid0 && (tag0 == addr_tag);
        hit1    = valid1 && (tag1 == addr_tag);
        hit     = hit0 || hit1;
        // The fill rule never leaves both ways valid with the same tag, so
        // hit1 alone is enough to identify the way.
        hit_way = hit1;
        line    = hit1 ? data1 : data0;
        word    = word_sel ? line[63:32] : line[31:0];
    end

endmodule : cache_lookup

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
// Two-way set-associative, write-through, read-allocate cache for the MEM
// stage. Owns the valid/tag/data/LRU arrays and the IDLE/FILL/WRITE FSM.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   cpu            cache_if.slave request bus (rd_en, wr_en, address, wdata,
//                  rdata, ready); the pipeline stalls on ~ready
//   sram_rd_en     line read request to the SRAM controller
//   sram_wr_en     word write request to the SRAM controller
//   sram_address   line-aligned address for reads, byte address for writes
//   sram_wdata     write data
//   sram_rdata     64-bit fetched line, [31:0] = word 0, [63:32] = word 1
//   sram_ready     SRAM transaction done this cycle
// -----------------------------------------------------------------------------
module cache_controller
    import cache_pkg::*;
#(
    parameter int SETS  = cache_pkg::SETS,
    parameter int TAG_W = cache_pkg::TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    cache_if.slave      cpu,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int INDEX_W = $clog2(SETS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [SETS-1:0]   valid0_q, valid0_d;
    logic [SETS-1:0]   valid1_q, valid1_d;
    logic [SETS-1:0]   lru_q, lru_d;          // way to evict next
    logic              sram_rd_en_q, sram_rd_en_d;
    logic              sram_wr_en_q, sram_wr_en_d;
    logic [31:0]       sram_address_q, sram_address_d;
    logic [31:0]       sram_wdata_q, sram_wdata_d;

    logic [TAG_W-1:0]  tag_mem  [2][SETS];
    logic [63:0]       data_mem [2][SETS];

    // ------------------------------------------------------------------
    // Address decode and lookup
    // ------------------------------------------------------------------
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   atag;
    logic               wsel;
    logic               is_write;
    logic               is_read;
    logic               hit;
    logic               hit_way;
    logic [31:0]        hit_word;
    logic               victim_way;
    logic               fill_we;
    logic               word_we;

    assign idx      = cpu.address[IDX_LSB +: INDEX_W];
    assign atag     = cpu.address[TAG_LSB +: TAG_W];
    assign wsel     = cpu.address[WSEL_BIT];
    // A simultaneous read and write request is serviced as a write.
    assign is_write = cpu.wr_en;
    assign is_read  = cpu.rd_en && !cpu.wr_en;

    cache_lookup #(
        .TAG_W (TAG_W)
    ) u_lookup (
        .valid0   (valid0_q[idx]),
        .valid1   (valid1_q[idx]),
        .tag0     (tag_mem[0][idx]),
        .tag1     (tag_mem[1][idx]),
        .data0    (data_mem[0][idx]),
        .data1    (data_mem[1][idx]),
        .addr_tag (atag),
        .word_sel (wsel),
        .hit      (hit),
        .hit_way  (hit_way),
        .word     (hit_word)
    );

    // Prefer an empty way; only fall back to LRU when the set is full.
    always_comb begin
        if (!valid0_q[idx]) begin
            victim_way = 1'b0;
        end else if (!valid1_q[idx]) begin
            victim_way = 1'b1;
        end else begin
            victim_way = lru_q[idx];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latch).
        state_d        = state_q;
        valid0_d       = valid0_q;
        valid1_d       = valid1_q;
        lru_d          = lru_q;
        sram_rd_en_d   = sram_rd_en_q;
        sram_wr_en_d   = sram_wr_en_q;
        sram_address_d = sram_address_q;
        sram_wdata_d   = sram_wdata_q;
        fill_we        = 1'b0;
        word_we        = 1'b0;
        cpu.ready      = 1'b0;
        cpu.rdata      = '0;

        case (state_q)
            IDLE: begin
                if (is_write) begin
                    state_d        = WRITE;
                    sram_wr_en_d   = 1'b1;
                    sram_address_d = cpu.address;
                    sram_wdata_d   = cpu.wdata;
                end else if (is_read) begin
                    if (hit) begin
                        cpu.ready  = 1'b1;
                        cpu.rdata  = hit_word;
                        lru_d[idx] = ~hit_way;
                    end else begin
                        state_d        = FILL;
                        sram_rd_en_d   = 1'b1;
                        sram_address_d = line_addr(cpu.address);
                    end
                end else begin
                    cpu.ready = 1'b1;
                end
            end

            FILL: begin
                if (sram_ready) begin
                    fill_we      = 1'b1;
                    if (victim_way) begin
                        valid1_d[idx] = 1'b1;
                    end else begin
                        valid0_d[idx] = 1'b1;
                    end
                    lru_d[idx]   = ~victim_way;
                    // Forward the fetched word straight to the pipeline.
                    cpu.ready    = 1'b1;
                    cpu.rdata    = wsel ? sram_rdata[63:32] : sram_rdata[31:0];
                    sram_rd_en_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            WRITE: begin
                if (sram_ready) begin
                    // Write-through without allocation: only a hit touches
                    // the arrays.
                    if (hit) begin
                        word_we    = 1'b1;
                        lru_d[idx] = ~hit_way;
                    end
                    cpu.ready    = 1'b1;
                    sram_wr_en_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d      = IDLE;
                sram_rd_en_d = 1'b0;
                sram_wr_en_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM, valid/LRU and SRAM-side output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // flop samples values from before this edge regardless of order.
        if (rst) begin
            state_q        <= IDLE;
            valid0_q       <= '0;
            valid1_q       <= '0;
            lru_q          <= '0;
            sram_rd_en_q   <= 1'b0;
            sram_wr_en_q   <= 1'b0;
            sram_address_q <= '0;
            sram_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            valid0_q       <= valid0_d;
            valid1_q       <= valid1_d;
            lru_q          <= lru_d;
            sram_rd_en_q   <= sram_rd_en_d;
            sram_wr_en_q   <= sram_wr_en_d;
            sram_address_q <= sram_address_d;
            sram_wdata_q   <= sram_wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays
    // ------------------------------------------------------------------
    // NOTE: the tag/data memories have no reset; the valid bits alone decide
    // whether their contents mean anything, which keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        // A reset arriving mid-transaction abandons it without touching
        // the arrays.
        if (!rst) begin
            if (fill_we) begin
                tag_mem[victim_way][idx]  <= atag;
                data_mem[victim_way][idx] <= sram_rdata;
            end
            if (word_we) begin
                if (wsel) begin
                    data_mem[hit_way][idx][63:32] <= cpu.wdata;
                end else begin
                    data_mem[hit_way][idx][31:0]  <= cpu.wdata;
                end
            end
        end
    end

    assign sram_rd_en   = sram_rd_en_q;
    assign sram_wr_en   = sram_wr_en_q;
    assign sram_address = sram_address_q;
    assign sram_wdata   = sram_wdata_q;

endmodule : cache_controller

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
// Self-checking bench for cache_controller. A behavioural SRAM with
// programmable latency backs the cache; a reference model of valid/tag/LRU
// state predicts hit or miss for every request, and the expected response
// (latency, read data, SRAM traffic) is queued when the request is driven and
// compared when the DUT raises ready.
// -----------------------------------------------------------------------------
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_if cpu_bus ();

    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    cache_controller #(
        .SETS  (64),
        .TAG_W (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (cpu_bus),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] actual,
                            input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Backing memory and SRAM controller model
    // ------------------------------------------------------------------
    logic [31:0] mem_words [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (mem_words.exists(k)) return mem_words[k];
        return (k * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    int sram_lat    = 1;
    int sram_cnt    = 0;
    int sram_rd_txn = 0;
    int sram_wr_txn = 0;
    bit stray_ready = 1'b0;

    initial begin
        sram_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(negedge clk);
            sram_ready = 1'b0;
            if (stray_ready) begin
                sram_ready  = 1'b1;
                stray_ready = 1'b0;
            end else if (sram_rd_en || sram_wr_en) begin
                sram_cnt++;
                if (sram_cnt >= sram_lat) begin
                    sram_ready = 1'b1;
                    sram_cnt   = 0;
                    if (sram_rd_en) begin
                        sram_rdata = {mem_read(sram_address + 32'd4), mem_read(sram_address)};
                        sram_rd_txn++;
                    end else begin
                        mem_words[{sram_address[31:2], 2'b00}] = sram_wdata;
                        sram_wr_txn++;
                    end
                end
            end else begin
                sram_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model of the cache directory
    // ------------------------------------------------------------------
    bit          m_valid [2][64];
    logic [9:0]  m_tag   [2][64];
    bit          m_lru   [64];

    task automatic model_clear();
        for (int s = 0; s < 64; s++) begin
            m_valid[0][s] = 1'b0;
            m_valid[1][s] = 1'b0;
            m_lru[s]      = 1'b0;
        end
    endtask

    typedef struct {
        bit          is_read;
        bit          uses_sram;
        int          wait_cyc;
        logic [31:0] rdata;
        logic [31:0] saddr;
        logic [31:0] swdata;
    } exp_t;

    exp_t sb[$];

    // ------------------------------------------------------------------
    // One request: predict, drive, wait for ready, compare.
    // ------------------------------------------------------------------
    task automatic request(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int lat);
        exp_t       e;
        exp_t       got;
        int         set;
        int         hway;
        int         v;
        int         rd0;
        int         wr0;
        int         cycles;
        bit         hit;
        bit         done;
        logic [9:0] tg;

        set  = int'(addr[8:3]);
        tg   = addr[18:9];
        hit  = 1'b0;
        hway = 0;
        for (int w = 0; w < 2; w++) begin
            if (m_valid[w][set] && m_tag[w][set] == tg) begin
                hit  = 1'b1;
                hway = w;
            end
        end

        e.is_read   = 1'b0;
        e.uses_sram = 1'b0;
        e.wait_cyc  = 0;
        e.rdata     = '0;
        e.saddr     = '0;
        e.swdata    = '0;
        if (wr) begin
            e.uses_sram = 1'b1;
            e.wait_cyc  = lat;
            e.saddr     = addr;
            e.swdata    = wd;
            if (hit) m_lru[set] = (hway == 0);
        end else begin
            e.is_read = 1'b1;
            e.rdata   = mem_read(addr);
            if (hit) begin
                m_lru[set] = (hway == 0);
            end else begin
                if (!m_valid[0][set])      v = 0;
                else if (!m_valid[1][set]) v = 1;
                else                       v = int'(m_lru[set]);
                m_valid[v][set] = 1'b1;
                m_tag[v][set]   = tg;
                m_lru[set]      = (v == 0);
                e.uses_sram     = 1'b1;
                e.wait_cyc      = lat;
                e.saddr         = {addr[31:3], 3'b000};
            end
        end
        sb.push_back(e);

        sram_lat = lat;
        @(negedge clk);
        rd0 = sram_rd_txn;
        wr0 = sram_wr_txn;
        cpu_bus.rd_en   = rd;
        cpu_bus.wr_en   = wr;
        cpu_bus.address = addr;
        cpu_bus.wdata   = wd;

        cycles = 0;
        done   = 1'b0;
        while (!done) begin
            #1;
            if (cycles == 0) begin
                check_eq("en_at_request", 64'({sram_rd_en, sram_wr_en}), 64'd0);
            end
            if (cycles == 1 && e.uses_sram) begin
                check_eq("sram_en", 64'({sram_rd_en, sram_wr_en}),
                         e.is_read ? 64'd2 : 64'd1);
                check_eq("sram_addr", 64'(sram_address), 64'(e.saddr));
                if (!e.is_read) check_eq("sram_wdata", 64'(sram_wdata), 64'(e.swdata));
            end
            if (cpu_bus.ready) begin
                done = 1'b1;
                got  = sb.pop_front();
                check_eq("latency", 64'(cycles), 64'(got.wait_cyc));
                if (got.is_read) check_eq("rdata", 64'(cpu_bus.rdata), 64'(got.rdata));
                check_eq("rd_txn", 64'(sram_rd_txn - rd0), 64'(got.is_read && got.uses_sram));
                check_eq("wr_txn", 64'(sram_wr_txn - wr0), 64'(!got.is_read));
            end else if (cycles >= 40) begin
                done = 1'b1;
                got  = sb.pop_front();
                check_eq("ready_timeout", 64'(cpu_bus.ready), 64'd1);
            end else begin
                @(negedge clk);
                cycles++;
            end
        end

        @(posedge clk);
        #1;
        check_eq("en_drop", 64'({sram_rd_en, sram_wr_en}), 64'd0);
        cpu_bus.rd_en = 1'b0;
        cpu_bus.wr_en = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        int          r;
        int          s;

        rst             = 1'b1;
        cpu_bus.rd_en   = 1'b0;
        cpu_bus.wr_en   = 1'b0;
        cpu_bus.address = '0;
        cpu_bus.wdata   = '0;
        model_clear();
        mem_words[32'h0000_0010] = 32'h1111_1111;
        mem_words[32'h0000_0014] = 32'h2222_2222;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_ready",      64'(cpu_bus.ready), 64'd1);
        check_eq("rst_rdata",      64'(cpu_bus.rdata), 64'd0);
        check_eq("rst_sram_rd_en", 64'(sram_rd_en),    64'd0);
        check_eq("rst_sram_wr_en", 64'(sram_wr_en),    64'd0);
        check_eq("rst_sram_addr",  64'(sram_address),  64'd0);
        check_eq("rst_sram_wdata", 64'(sram_wdata),    64'd0);

        // Cold miss, then a hit on the other word of the same line.
        request(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2);
        request(1'b1, 1'b0, 32'h0000_0014, 32'h0, 2);

        // Fill set 2 with three tags; the third evicts way0, the re-read of
        // 0x010 evicts way1 (tag 0x210).
        request(1'b1, 1'b0, 32'h0000_0210, 32'h0, 1);
        request(1'b1, 1'b0, 32'h0000_0410, 32'h0, 3);
        request(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2);

        // Write hit, then read back the new value from the cache.
        request(1'b0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 2);
        request(1'b1, 1'b0, 32'h0000_0014, 32'h0, 2);
        request(1'b1, 1'b0, 32'h0000_0210, 32'h0, 1);

        // Write miss: written through, not allocated.
        request(1'b0, 1'b1, 32'h0000_7F08, 32'hCAFE_F00D, 3);
        request(1'b1, 1'b0, 32'h0000_7F08, 32'h0, 2);

        // Read and write together behave as a write.
        request(1'b1, 1'b1, 32'h0000_7F0C, 32'h0BAD_C0DE, 1);
        request(1'b1, 1'b0, 32'h0000_7F0C, 32'h0, 1);

        // Highest set, both words.
        request(1'b1, 1'b0, 32'h0000_01FC, 32'h0, 1);
        request(1'b1, 1'b0, 32'h0000_01F8, 32'h0, 1);

        // Stray sram_ready while idle must be ignored.
        @(posedge clk);
        stray_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("stray_ready_idle", 64'(cpu_bus.ready), 64'd1);
        @(posedge clk);
        #1;
        check_eq("stray_no_enable", 64'({sram_rd_en, sram_wr_en}), 64'd0);
        request(1'b1, 1'b0, 32'h0000_01F8, 32'h0, 1);

        // Random mix over two sets and four tags.
        for (int i = 0; i < 30; i++) begin
            s = ($urandom_range(0, 1) == 1) ? 63 : 2;
            a = {13'd0, 10'($urandom_range(0, 3)), 6'(s), 1'($urandom_range(0, 1)), 2'b00};
            r = $urandom_range(0, 7);
            if (r < 2)       request(1'b0, 1'b1, a, $urandom, $urandom_range(1, 3));
            else if (r == 2) request(1'b1, 1'b1, a, $urandom, $urandom_range(1, 3));
            else             request(1'b1, 1'b0, a, 32'h0, $urandom_range(1, 3));
        end

        // Reset in the middle of a fill.
        sram_lat = 6;
        @(negedge clk);
        cpu_bus.rd_en   = 1'b1;
        cpu_bus.wr_en   = 1'b0;
        cpu_bus.address = 32'h0004_0C18;
        repeat (2) @(negedge clk);
        #1;
        check_eq("fill_pending", 64'(sram_rd_en), 64'd1);
        @(negedge clk);
        rst           = 1'b1;
        cpu_bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_fill_en",    64'({sram_rd_en, sram_wr_en}), 64'd0);
        check_eq("rst_fill_ready", 64'(cpu_bus.ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        request(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2);
        request(1'b1, 1'b0, 32'h0004_0C18, 32'h0, 1);
        request(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule : tb_cache_controller
